play_sched: RTL and testbench
=============================

Name: play_sched

Overview:
- Playback scheduler for the music player.
- Sequences the note-address counter that feeds the tone ROM/generator, and selects the active song.
- Arbitrates four event sources: user song-select change pulses (from the register-change flag block), next/prev/play-pause key pulses, end-of-song, and the beat tick.
- Sits between the key/switch conditioning blocks and the note ROM / tone datapath.

Parameters:
- SW, 3, width of song index.
- NUM_SONGS, 6, number of valid songs; indices 0..NUM_SONGS-1 (NUM_SONGS <= 2**SW).
- AW, 8, note address width.
- GAP_BEATS, 4, silent beats between consecutive songs (>=1).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- sel_flag  in  1  one-cycle pulse: song-select register changed
- sel_val  in  SW  new song index, valid with sel_flag
- key_play  in  1  one-cycle pulse: toggle play/pause
- key_next  in  1  one-cycle pulse: next song
- key_prev  in  1  one-cycle pulse: previous song
- beat_tick  in  1  one-cycle pulse per note beat
- song_end  in  1  level from ROM: current note_addr is the end marker
- song_idx  out  SW  active song index (registered)
- note_addr  out  AW  note address to ROM (registered)
- playing  out  1  high in PLAY only; gates the tone output
- restart  out  1  one-cycle pulse when a song (re)starts at address 0
- state_o  out  3  current FSM state encoding, for debug

Behaviour:
- States (state_o encoding):
  - IDLE=0: silent, wait for key_play.
  - LOAD=1: exactly 1 cycle; note_addr<=0, restart=1; next state is PLAY if play_req=1, else PAUSE.
  - PLAY=2: on beat_tick, if song_end=1 go to GAP (gap_cnt<=0), else note_addr<=note_addr+1. note_addr wraps at 2**AW-1 to 0, no error.
  - PAUSE=3: note_addr held; key_play -> PLAY.
  - GAP=4: gap_cnt increments on beat_tick; when gap_cnt==GAP_BEATS-1 and beat_tick, advance song_idx and go to LOAD.
- play_req is an internal flag:
  - LOAD->PLAY sets it; LOAD->PAUSE leaves it clear.
  - key_play in PLAY clears it and enters PAUSE.
  - key_play in IDLE sets it and enters LOAD.
- Song index arithmetic:
  - next = (idx==NUM_SONGS-1) ? 0 : idx+1.
  - prev = (idx==0) ? NUM_SONGS-1 : idx-1.
  - sel_val >= NUM_SONGS: the whole event is ignored, and song_idx and state are unchanged.
- Event priority when several arrive in the same cycle, highest first:
  1. sel_flag
  2. key_next
  3. key_prev
  4. key_play
  5. beat_tick/song_end
- Only the highest-priority event is acted on; the others are dropped, not queued.
- In PLAY, PAUSE and GAP, sel_flag, key_next and key_prev update song_idx and go to LOAD. play_req is preserved, so a paused player stays paused at address 0 of the new song.
- In IDLE:
  - sel_flag, key_next and key_prev update song_idx only; the state stays IDLE.
  - key_play -> LOAD.
- Events during LOAD are dropped; LOAD always completes in one cycle.
- beat_tick and song_end are ignored outside PLAY/GAP.
- Latency:
  - Any accepted event updates song_idx/state on the next clk edge.
  - restart is high the cycle after entry to LOAD, aligned with note_addr=0.
- Reset values: state=IDLE, song_idx=0, note_addr=0, playing=0, restart=0, play_req=0, gap_cnt=0. Reset asserted mid-song returns to IDLE in one cycle.
- Outputs: all registered; playing = (state==PLAY).

Optional Feature:
- Macro: PLAY_SCHED_REPEAT_ONE_EN.
- Defined: GAP completion reloads the same song_idx (no advance); key_next/key_prev still change the song.
- Undefined: GAP completion advances to the next song with wrap, as above.

Test Plan:
- Reset, then key_play: state 0->1->2; restart pulses once; note_addr=0. After 3 beat_ticks, note_addr=3 and playing=1.
- song_idx=5, NUM_SONGS=6, song_end=1 on a beat_tick in PLAY -> GAP. After 4 beat_ticks: song_idx=0, LOAD, restart, PLAY. With PLAY_SCHED_REPEAT_ONE_EN defined, song_idx stays 5.
- In PLAY at note_addr=7, sel_flag with sel_val=2 in the same cycle as key_next: song_idx=2 (not 3), note_addr=0, restart pulse, back to PLAY.
- key_play in PLAY -> PAUSE, note_addr held at its value. key_prev at song_idx=0 -> song_idx=5, LOAD then PAUSE (playing stays 0).
- sel_flag with sel_val=7 (NUM_SONGS=6) -> no change to song_idx or state. In IDLE, sel_flag with sel_val=3 -> song_idx=3, state remains IDLE.
- rst asserted in GAP with gap_cnt=2 -> next cycle: all outputs at reset values, state_o=0.

Source files
------------

// File: rtl/play_sched.sv
// play_sched: playback scheduler for the music player.
//
// Steps the note-address counter that feeds the note ROM / tone datapath and
// chooses the active song. Four kinds of event are arbitrated each cycle, highest
// priority first: song-select change, next, prev, play/pause, then beat/end-of-song.
// Only the highest-priority event present in a cycle is acted on. Lower-priority
// events in that cycle are dropped.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   sel_flag   pulse: song-select register changed (sel_val valid)
//   sel_val    requested song index; values >= NUM_SONGS are ignored
//   key_play   pulse: toggle play/pause (starts playback from IDLE)
//   key_next   pulse: next song (wraps)
//   key_prev   pulse: previous song (wraps)
//   beat_tick  pulse: one per note beat
//   song_end   level: current note_addr holds the end marker
//   song_idx   active song index (registered)
//   note_addr  note address to ROM (registered)
//   playing    high only while in PLAY
//   restart    one-cycle pulse, aligned with note_addr returning to 0 after LOAD
//   state_o    FSM state encoding: IDLE=0 LOAD=1 PLAY=2 PAUSE=3 GAP=4
//
// Build option:
//   PLAY_SCHED_REPEAT_ONE_EN  when defined, the end of the inter-song gap reloads
//                             the same song instead of advancing to the next one.

module play_sched #(
  parameter int unsigned SW        = 3,
  parameter int unsigned NUM_SONGS = 6,
  parameter int unsigned AW        = 8,
  parameter int unsigned GAP_BEATS = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel_flag,
  input  logic [SW-1:0] sel_val,
  input  logic          key_play,
  input  logic          key_next,
  input  logic          key_prev,
  input  logic          beat_tick,
  input  logic          song_end,
  output logic [SW-1:0] song_idx,
  output logic [AW-1:0] note_addr,
  output logic          playing,
  output logic          restart,
  output logic [2:0]    state_o
);

  localparam int unsigned GW = (GAP_BEATS > 1) ? $clog2(GAP_BEATS) : 1;

  localparam logic [SW-1:0] LastSong  = SW'(NUM_SONGS - 1);
  localparam logic [SW:0]   NumSongsW = (SW + 1)'(NUM_SONGS);
  localparam logic [GW-1:0] GapLast   = GW'(GAP_BEATS - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StPlay  = 3'd2,
    StPause = 3'd3,
    StGap   = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] song_q, song_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          req_q, req_d;
  logic          restart_q, restart_d;
  logic          playing_q, playing_d;

  logic [SW-1:0] song_next, song_prev, song_after_gap;
  logic          sel_ok;

  assign song_next = (song_q == LastSong) ? '0 : song_q + 1'b1;
  assign song_prev = (song_q == '0) ? LastSong : song_q - 1'b1;
  assign sel_ok    = ({1'b0, sel_val} < NumSongsW);

`ifdef PLAY_SCHED_REPEAT_ONE_EN
  assign song_after_gap = song_q;
`else
  assign song_after_gap = song_next;
`endif

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      song_q    <= '0;
      addr_q    <= '0;
      gap_q     <= '0;
      req_q     <= 1'b0;
      restart_q <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      song_q    <= song_d;
      addr_q    <= addr_d;
      gap_q     <= gap_d;
      req_q     <= req_d;
      restart_q <= restart_d;
      playing_q <= playing_d;
    end
  end

  // Next-state and datapath update with fixed event priority.
  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    addr_d  = addr_q;
    gap_d   = gap_q;
    req_d   = req_q;

    unique case (state_q)
      StIdle: begin
        // Song changes while idle only update the index; playback needs key_play.
        if (sel_flag) begin
          if (sel_ok) song_d = sel_val;
        end else if (key_next) begin
          song_d = song_next;
        end else if (key_prev) begin
          song_d = song_prev;
        end else if (key_play) begin
          req_d   = 1'b1;
          state_d = StLoad;
        end
      end

      StLoad: begin
        // Events arriving here are dropped; req_q picks play or pause.
        addr_d  = '0;
        state_d = req_q ? StPlay : StPause;
      end

      StPlay, StPause, StGap: begin
        if (sel_flag) begin
          // An out-of-range selection swallows the whole cycle.
          if (sel_ok) begin
            song_d  = sel_val;
            state_d = StLoad;
          end
        end else if (key_next) begin
          song_d  = song_next;
          state_d = StLoad;
        end else if (key_prev) begin
          song_d  = song_prev;
          state_d = StLoad;
        end else if (key_play) begin
          if (state_q == StPlay) begin
            req_d   = 1'b0;
            state_d = StPause;
          end else if (state_q == StPause) begin
            req_d   = 1'b1;
            state_d = StPlay;
          end
        end else if (beat_tick) begin
          if (state_q == StPlay) begin
            if (song_end) begin
              gap_d   = '0;
              state_d = StGap;
            end else begin
              addr_d = addr_q + 1'b1;
            end
          end else if (state_q == StGap) begin
            if (gap_q == GapLast) begin
              song_d  = song_after_gap;
              state_d = StLoad;
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Registered output next values.
  always_comb begin
    restart_d = (state_q == StLoad);
    playing_d = (state_d == StPlay);
  end

  assign song_idx  = song_q;
  assign note_addr = addr_q;
  assign playing   = playing_q;
  assign restart   = restart_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_play_sched.sv
module tb_play_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_flag;
  logic [2:0] sel_val;
  logic       key_play, key_next, key_prev, beat_tick, song_end;
  logic [2:0] song_idx;
  logic [7:0] note_addr;
  logic       playing, restart;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  play_sched #(
    .SW       (3),
    .NUM_SONGS(6),
    .AW       (8),
    .GAP_BEATS(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sel_flag (sel_flag),
    .sel_val  (sel_val),
    .key_play (key_play),
    .key_next (key_next),
    .key_prev (key_prev),
    .beat_tick(beat_tick),
    .song_end (song_end),
    .song_idx (song_idx),
    .note_addr(note_addr),
    .playing  (playing),
    .restart  (restart),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  // One clock edge, then clear all pulse inputs; outputs sampled 1ns after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    sel_flag  = 1'b0;
    key_play  = 1'b0;
    key_next  = 1'b0;
    key_prev  = 1'b0;
    beat_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [2:0] exp_after_gap;

  initial begin
`ifdef PLAY_SCHED_REPEAT_ONE_EN
    exp_after_gap = 3'd5;
`else
    exp_after_gap = 3'd0;
`endif
    rst = 1'b1; sel_flag = 0; sel_val = 0; key_play = 0; key_next = 0; key_prev = 0;
    beat_tick = 0; song_end = 0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("reset_state", 32'(state_o), 0);
    chk("reset_song", 32'(song_idx), 0);
    chk("reset_addr", 32'(note_addr), 0);
    chk("reset_playing", 32'(playing), 0);
    chk("reset_restart", 32'(restart), 0);

    // Start playback: IDLE -> LOAD -> PLAY, restart aligned with address 0.
    key_play = 1; cyc();
    chk("start_load", 32'(state_o), 1);
    chk("start_load_restart", 32'(restart), 0);
    cyc();
    chk("start_play", 32'(state_o), 2);
    chk("start_restart", 32'(restart), 1);
    chk("start_addr", 32'(note_addr), 0);
    chk("start_playing", 32'(playing), 1);
    cyc();
    chk("restart_once", 32'(restart), 0);
    for (int i = 0; i < 3; i++) begin beat_tick = 1; cyc(); end
    chk("three_beats_addr", 32'(note_addr), 3);
    chk("three_beats_playing", 32'(playing), 1);
    cyc();
    chk("no_beat_hold", 32'(note_addr), 3);

    // sel_flag beats key_next in the same cycle.
    for (int i = 0; i < 4; i++) begin beat_tick = 1; cyc(); end
    chk("addr_seven", 32'(note_addr), 7);
    sel_flag = 1; sel_val = 2; key_next = 1; cyc();
    chk("prio_song", 32'(song_idx), 2);
    chk("prio_load", 32'(state_o), 1);
    cyc();
    chk("prio_play", 32'(state_o), 2);
    chk("prio_addr", 32'(note_addr), 0);
    chk("prio_restart", 32'(restart), 1);

    // Pause holds the address and ignores beats.
    beat_tick = 1; cyc(); beat_tick = 1; cyc();
    key_play = 1; cyc();
    chk("pause_state", 32'(state_o), 3);
    chk("pause_playing", 32'(playing), 0);
    chk("pause_addr", 32'(note_addr), 2);
    beat_tick = 1; cyc();
    chk("pause_beat_addr", 32'(note_addr), 2);

    // Song change while paused reloads and stays paused.
    sel_flag = 1; sel_val = 0; cyc();
    chk("psel_load", 32'(state_o), 1);
    chk("psel_song", 32'(song_idx), 0);
    cyc();
    chk("psel_pause", 32'(state_o), 3);
    chk("psel_addr", 32'(note_addr), 0);
    chk("psel_restart", 32'(restart), 1);
    key_prev = 1; cyc();
    chk("prev_wrap_song", 32'(song_idx), 5);
    chk("prev_wrap_load", 32'(state_o), 1);
    chk("prev_wrap_playing", 32'(playing), 0);
    cyc();
    chk("prev_wrap_pause", 32'(state_o), 3);
    chk("prev_wrap_playing2", 32'(playing), 0);

    // Out-of-range selection is ignored.
    sel_flag = 1; sel_val = 7; cyc();
    chk("badsel_song", 32'(song_idx), 5);
    chk("badsel_state", 32'(state_o), 3);

    // Resume, end of song, gap of four beats, then next song (or same with repeat).
    key_play = 1; cyc();
    chk("resume_state", 32'(state_o), 2);
    song_end = 1; beat_tick = 1; cyc(); song_end = 0;
    chk("gap_enter", 32'(state_o), 4);
    chk("gap_playing", 32'(playing), 0);
    for (int i = 0; i < 3; i++) begin beat_tick = 1; cyc(); end
    cyc();
    chk("gap_hold", 32'(state_o), 4);
    beat_tick = 1; cyc();
    chk("gap_done_load", 32'(state_o), 1);
    chk("gap_done_song", 32'(song_idx), 32'(exp_after_gap));
    cyc();
    chk("gap_play", 32'(state_o), 2);
    chk("gap_restart", 32'(restart), 1);
    chk("gap_addr", 32'(note_addr), 0);

    // Move to a nonzero song, reach GAP with gap_cnt=2, then reset.
    sel_flag = 1; sel_val = 1; cyc(); cyc();
    beat_tick = 1; cyc();
    chk("pre_reset_addr", 32'(note_addr), 1);
    song_end = 1; beat_tick = 1; cyc(); song_end = 0;
    beat_tick = 1; cyc(); beat_tick = 1; cyc();
    chk("pre_reset_gap", 32'(state_o), 4);
    rst = 1; cyc(); rst = 0;
    chk("midreset_state", 32'(state_o), 0);
    chk("midreset_song", 32'(song_idx), 0);
    chk("midreset_addr", 32'(note_addr), 0);
    chk("midreset_playing", 32'(playing), 0);
    chk("midreset_restart", 32'(restart), 0);

    // Idle song changes update the index only.
    sel_flag = 1; sel_val = 3; cyc();
    chk("idle_sel_song", 32'(song_idx), 3);
    chk("idle_sel_state", 32'(state_o), 0);
    key_next = 1; cyc();
    chk("idle_next_song", 32'(song_idx), 4);
    chk("idle_next_state", 32'(state_o), 0);

    // Address wraps from 255 to 0.
    key_play = 1; cyc(); cyc();
    chk("wrap_start", 32'(state_o), 2);
    for (int i = 0; i < 255; i++) begin beat_tick = 1; cyc(); end
    chk("addr_max", 32'(note_addr), 255);
    beat_tick = 1; cyc();
    chk("addr_wrap", 32'(note_addr), 0);
    chk("addr_wrap_state", 32'(state_o), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
